// File: rtl/downscale_seq_ctrl.sv
// downscale_seq_ctrl: raster walker issuing bilinear source-coordinate tokens; DOWNSCALE_PERF_CNT_EN adds a busy-cycle counter
module downscale_seq_ctrl #(
  parameter int DIM_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              start_pulse,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [DIM_W-1:0]  cfg_scale,
  input  logic              step_mode,
  input  logic              step_pulse,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [DIM_W-1:0]  src_x,
  output logic [DIM_W-1:0]  src_y,
  output logic [FRAC_W-1:0] frac_x,
  output logic [FRAC_W-1:0] frac_y,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DIM_W-1:0]  pix_count,
  output logic [31:0]       perf_cycles
);
  localparam int PW = DIM_W + FRAC_W;
  localparam logic [DIM_W-1:0] SCALE_MIN = DIM_W'(1 << FRAC_W);
  typedef enum logic [1:0] {IDLE, CHECK, RUN, FIN} state_t;
  state_t state, state_next;
  logic [DIM_W-1:0] width_q, height_q, scale_q;
  logic [PW-1:0] pos_x, pos_y;
  logic [PW:0] nxt_x, nxt_y;
  logic credit, cfg_ok, accept, xfer, wrap, frame_end, avail, load;
  assign src_x = pos_x[PW-1:FRAC_W];
  assign frac_x = pos_x[FRAC_W-1:0];
  assign src_y = pos_y[PW-1:FRAC_W];
  assign frac_y = pos_y[FRAC_W-1:0];
  assign last = px_valid && frame_end;
  assign busy = state == RUN || (state == CHECK && cfg_ok);
  // next-state and token bookkeeping; positions carry one spare bit so the step never wraps
  always_comb begin
    cfg_ok = width_q != '0 && height_q != '0 && scale_q >= SCALE_MIN;
    accept = state == IDLE && start_pulse;
    xfer = px_valid && px_ready;
    nxt_x = {1'b0, pos_x} + {{(FRAC_W+1){1'b0}}, scale_q};
    nxt_y = {1'b0, pos_y} + {{(FRAC_W+1){1'b0}}, scale_q};
    wrap = nxt_x[PW:FRAC_W] >= {1'b0, width_q};
    frame_end = wrap && nxt_y[PW:FRAC_W] >= {1'b0, height_q};
    avail = !step_mode || credit;
    load = avail && ((state == CHECK && cfg_ok) || (state == RUN && (!px_valid || (xfer && !frame_end))));
    state_next = state == IDLE ? (start_pulse ? CHECK : IDLE)
               : state == CHECK ? (cfg_ok ? RUN : FIN)
               : state == RUN ? (xfer && frame_end ? FIN : RUN)
               : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge aclr)
    if (!aclr) state <= IDLE;
    else state <= state_next;
  // shadow config, raster position, token handshake, step credit and status
  always_ff @(posedge clk or negedge aclr)
    if (!aclr) begin
      width_q <= '0;
      height_q <= '0;
      scale_q <= '0;
      pos_x <= '0;
      pos_y <= '0;
      pix_count <= '0;
      px_valid <= 1'b0;
      credit <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      if (accept) begin
        width_q <= cfg_width;
        height_q <= cfg_height;
        scale_q <= cfg_scale;
        pos_x <= '0;
        pos_y <= '0;
        pix_count <= '0;
        done <= 1'b0;
        err <= 1'b0;
      end
      if (state == CHECK && !cfg_ok) begin
        done <= 1'b1;
        err <= 1'b1;
      end
      if (xfer) begin
        pix_count <= pix_count + DIM_W'(1);
        pos_x <= wrap ? '0 : nxt_x[PW-1:0];
        pos_y <= wrap ? nxt_y[PW-1:0] : pos_y;
        if (frame_end) done <= 1'b1;
      end
      px_valid <= load || (px_valid && !xfer);
      credit <= step_pulse || (credit && !(load && step_mode));
    end
`ifdef DOWNSCALE_PERF_CNT_EN
  // busy-cycle counter, cleared on accepted start, saturating
  always_ff @(posedge clk or negedge aclr)
    if (!aclr) perf_cycles <= '0;
    else if (accept) perf_cycles <= '0;
    else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
`else
  assign perf_cycles = '0;
`endif
endmodule
